id_ex_stage: RTL

ID/EX boundary of the 5-stage MIPS pipeline: captures the decoded control bundle produced by the ID-stage control decoder together with register-file operands and instruction fields, and presents them registered to the EX stage. It contains load-use hazard detection, inserting exactly one bubble and holding PC/IF-ID for a `lw` followed by a dependent instruction. It also squashes the ID instruction on a taken branch/jump flush and counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register of a 5-stage MIPS pipeline. Captures the decoded
//   control bundle, register-file operands and instruction fields from ID and
//   presents them registered to EX. Detects load-use hazards (lw in EX whose
//   destination is a source of the ID instruction), requests a one-cycle hold
//   of PC and IF/ID, and loads a bubble instead. A taken branch/jump flush
//   also loads a bubble and overrides the hazard. Inserted load-use bubbles
//   are counted in a saturating counter.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   flush_i                 squash the instruction currently in ID
//   *_i control bundle      ALUSrc, RegDst, MemWr, MemRd, MemtoReg, RegWr,
//                           Branch, Jump (1 bit each), ALUOp (2 bits)
//   rs_data_i, rt_data_i    register-file read data
//   imm_i                   sign-extended immediate
//   rs_i, rt_i, rd_i        register specifiers, funct_i funct field
//   stall_o                 combinational hold request for PC and IF/ID
//   ex_*                    registered bundle seen by EX; ex_valid_o=0 = bubble
//   bubble_cnt_o            saturating count of load-use bubbles
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic              MemWr_i,
  input  logic              MemRd_i,
  input  logic              MemtoReg_i,
  input  logic              RegWr_i,
  input  logic              Branch_i,
  input  logic              Jump_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [5:0]        funct_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              ex_ALUSrc_o,
  output logic              ex_RegDst_o,
  output logic              ex_MemWr_o,
  output logic              ex_MemRd_o,
  output logic              ex_MemtoReg_o,
  output logic              ex_RegWr_o,
  output logic [1:0]        ex_ALUOp_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_rs_o,
  output logic [4:0]        ex_rt_o,
  output logic [4:0]        ex_rd_o,
  output logic [5:0]        ex_funct_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic w_uses_rs;
  logic w_uses_rt;
  logic w_rs_match;
  logic w_rt_match;
  logic w_hazard;

  // Jumps read no register; rt is a source only for R-type, sw and beq.
  assign w_uses_rs  = ~Jump_i;
  assign w_uses_rt  = RegDst_i | MemWr_i | Branch_i;
  assign w_rs_match = w_uses_rs & (rs_i == ex_rt_o);
  assign w_rt_match = w_uses_rt & (rt_i == ex_rt_o);

  // A load targeting $0 never produces a value anyone waits for.
  assign w_hazard = ex_valid_o & ex_MemRd_o & (ex_rt_o != 5'd0) &
                    (w_rs_match | w_rt_match);

  assign stall_o = w_hazard & ~flush_i;

  // A bubble clears ex_MemRd_o, so the held instruction sees no hazard on the
  // next edge and is captured: exactly one bubble per load-use pair.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_ALUSrc_o   <= 1'b0;
      ex_RegDst_o   <= 1'b0;
      ex_MemWr_o    <= 1'b0;
      ex_MemRd_o    <= 1'b0;
      ex_MemtoReg_o <= 1'b0;
      ex_RegWr_o    <= 1'b0;
      ex_ALUOp_o    <= '0;
      ex_rs_data_o  <= '0;
      ex_rt_data_o  <= '0;
      ex_imm_o      <= '0;
      ex_rs_o       <= '0;
      ex_rt_o       <= '0;
      ex_rd_o       <= '0;
      ex_funct_o    <= '0;
      bubble_cnt_o  <= '0;
    end else if (flush_i || w_hazard) begin
      ex_valid_o    <= 1'b0;
      ex_ALUSrc_o   <= 1'b0;
      ex_RegDst_o   <= 1'b0;
      ex_MemWr_o    <= 1'b0;
      ex_MemRd_o    <= 1'b0;
      ex_MemtoReg_o <= 1'b0;
      ex_RegWr_o    <= 1'b0;
      ex_ALUOp_o    <= '0;
      ex_rs_data_o  <= '0;
      ex_rt_data_o  <= '0;
      ex_imm_o      <= '0;
      ex_rs_o       <= '0;
      ex_rt_o       <= '0;
      ex_rd_o       <= '0;
      ex_funct_o    <= '0;
      // Only load-use bubbles are counted; a flush wins over a hazard.
      if (!flush_i && (bubble_cnt_o != '1)) begin
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
    end else begin
      ex_valid_o    <= 1'b1;
      ex_ALUSrc_o   <= ALUSrc_i;
      ex_RegDst_o   <= RegDst_i;
      ex_MemWr_o    <= MemWr_i;
      ex_MemRd_o    <= MemRd_i;
      ex_MemtoReg_o <= MemtoReg_i;
      ex_RegWr_o    <= RegWr_i;
      ex_ALUOp_o    <= ALUOp_i;
      ex_rs_data_o  <= rs_data_i;
      ex_rt_data_o  <= rt_data_i;
      ex_imm_o      <= imm_i;
      ex_rs_o       <= rs_i;
      ex_rt_o       <= rt_i;
      ex_rd_o       <= rd_i;
      ex_funct_o    <= funct_i;
    end
  end

endmodule
